delay_line_ctrl: RTL and testbench

//  Runtime-programmable sample delay line with sequencing control. It replaces fixed-length shift

---
 rtl/delay_line_if.sv | 25 ++
 rtl/delay_line_ctrl.sv | 125 ++++++++++++
 tb/tb_delay_line_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/delay_line_if.sv
// Bundles the configuration, status and sample-stream signals of the delay line.
interface delay_line_if #(
    parameter int DW = 16,
    parameter int LW = 7
);
    logic [LW-1:0]        cfg_len;
    logic                 cfg_load;
    logic                 cfg_err;
    logic [LW-1:0]        cur_len;
    logic                 primed;
    logic signed [DW-1:0] d_in;
    logic                 d_in_val;
    logic signed [DW-1:0] d_out;
    logic                 d_out_val;

    modport master (
        output cfg_len, cfg_load, d_in, d_in_val,
        input  cfg_err, cur_len, primed, d_out, d_out_val
    );

    modport slave (
        input  cfg_len, cfg_load, d_in, d_in_val,
        output cfg_err, cur_len, primed, d_out, d_out_val
    );
endinterface

// File: rtl/delay_line_ctrl.sv
// Runtime-programmable sample delay: circular buffer with a FILL/RUN sequencer that
// withholds output until a full window of the current length has been written.
module delay_line_ctrl #(
    parameter int MAX_LEN = 64,
    parameter int DW      = 16,
    parameter int DEF_LEN = 8
) (
    input  logic          clk,
    input  logic          rst,
    delay_line_if.slave   bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LW:0]   MAX_LEN_X = (LW + 1)'(MAX_LEN);
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
    localparam logic [LW-1:0] DEF_LEN_L = LW'(DEF_LEN);
    localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_LEN - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] cur_len_q, cur_len_d;
    logic [LW-1:0] fill_cnt_q, fill_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] d_out_q, d_out_d;
    logic          d_out_val_q, d_out_val_d;
    logic          cfg_err_q, cfg_err_d;

    logic [DW-1:0] mem [MAX_LEN];
    logic [PW-1:0] rd_ptr;
    logic [LW:0]   wr_ext;
    logic [LW:0]   len_ext;
    logic          cfg_ok;
    logic [LW-1:0] fill_inc;

    // Read pointer trails the write pointer by cur_len, folded back into range without a mask.
    always_comb begin
        wr_ext  = (LW + 1)'(wr_ptr_q);
        len_ext = {1'b0, cur_len_q};
        if (wr_ext >= len_ext) begin
            rd_ptr = PW'(wr_ext - len_ext);
        end else begin
            rd_ptr = PW'(wr_ext + MAX_LEN_X - len_ext);
        end
    end

    always_comb begin
        cfg_ok   = bus.cfg_load && (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);
        fill_inc = fill_cnt_q + LW'(1);

        state_d     = state_q;
        cur_len_d   = cur_len_q;
        fill_cnt_d  = fill_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        d_out_d     = d_out_q;
        d_out_val_d = 1'b0;
        cfg_err_d   = 1'b0;

        if (bus.d_in_val) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end

        // An accepted load restarts the fill; a coincident sample becomes sample 0 of it.
        if (cfg_ok) begin
            cur_len_d  = bus.cfg_len;
            state_d    = FILL;
            fill_cnt_d = bus.d_in_val ? LW'(1) : '0;
            if (bus.d_in_val && (bus.cfg_len == LW'(1))) begin
                state_d = RUN;
            end
        end else begin
            cfg_err_d = bus.cfg_load;
            case (state_q)
                FILL: begin
                    if (bus.d_in_val) begin
                        fill_cnt_d = fill_inc;
                        if (fill_inc == cur_len_q) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.d_in_val) begin
                        d_out_d     = mem[rd_ptr];
                        d_out_val_d = 1'b1;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FILL;
            cur_len_q   <= DEF_LEN_L;
            fill_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            d_out_q     <= '0;
            d_out_val_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_len_q   <= cur_len_d;
            fill_cnt_q  <= fill_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            d_out_q     <= d_out_d;
            d_out_val_q <= d_out_val_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Sample storage is left uninitialised; FILL keeps stale words off the output.
    always_ff @(posedge clk) begin
        if (rst && bus.d_in_val) begin
            mem[wr_ptr_q] <= bus.d_in;
        end
    end

    assign bus.cfg_err   = cfg_err_q;
    assign bus.cur_len   = cur_len_q;
    assign bus.primed    = (state_q == RUN);
    assign bus.d_out     = d_out_q;
    assign bus.d_out_val = d_out_val_q;
endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl against a sample-history reference model.
module tb_delay_line_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    delay_line_if #(.DW(16), .LW(7)) bus ();

    delay_line_ctrl #(.MAX_LEN(64), .DW(16), .DEF_LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: every valid sample since the last accepted load or reset.
    logic [15:0] hist[$];
    int          len_m;
    logic        exp_val;
    logic [15:0] exp_out;
    logic        exp_err;
    logic        exp_primed;

    task automatic cycle(input logic v, input logic [15:0] d, input logic ld, input logic [6:0] len);
        int  n;
        logic acc;
        @(negedge clk);
        bus.d_in_val = v;
        bus.d_in     = d;
        bus.cfg_load = ld;
        bus.cfg_len  = len;
        @(posedge clk);
        if (!rst) begin
            hist.delete();
            len_m   = 8;
            exp_val = 1'b0;
            exp_out = '0;
            exp_err = 1'b0;
        end else begin
            acc     = ld && (len >= 1) && (len <= 64);
            exp_err = ld && !acc;
            exp_val = 1'b0;
            if (acc) begin
                len_m = int'(len);
                hist.delete();
            end
            if (v) begin
                n = hist.size();
                if (n >= len_m) begin
                    exp_val = 1'b1;
                    exp_out = hist[n - len_m];
                end
                hist.push_back(d);
            end
        end
        exp_primed = (hist.size() >= len_m);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cycle(1'b0, 16'h0, 1'b0, 7'd0);
        cycle(1'b1, 16'h1234, 1'b0, 7'd0);
        checks++; if (bus.d_out_val !== 1'b0) begin errors++; $display("[TB] FAIL reset_val got=%b exp=0", bus.d_out_val); end
        checks++; if (bus.d_out !== 16'h0) begin errors++; $display("[TB] FAIL reset_out got=%h exp=0", bus.d_out); end
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", bus.cfg_err); end
        checks++; if (bus.primed !== 1'b0) begin errors++; $display("[TB] FAIL reset_primed got=%b exp=0", bus.primed); end
        checks++; if (bus.cur_len !== 7'd8) begin errors++; $display("[TB] FAIL reset_len got=%0d exp=8", bus.cur_len); end
        rst = 1'b1;
    endtask

    task automatic test_default_stream();
        int pulses = 0;
        int first  = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 16'(i), 1'b0, 7'd0);
            checks++; if (bus.d_out_val !== exp_val) begin errors++; $display("[TB] FAIL def_val in=%0d got=%b exp=%b", i, bus.d_out_val, exp_val); end
            checks++; if (bus.d_out !== exp_out) begin errors++; $display("[TB] FAIL def_out in=%0d got=%h exp=%h", i, bus.d_out, exp_out); end
            if (bus.d_out_val === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    checks++; if (bus.d_out !== 16'd1 || bus.primed !== 1'b1) begin errors++; $display("[TB] FAIL def_first got=%h primed=%b exp=1/1", bus.d_out, bus.primed); end
                end
            end
        end
        checks++; if (first != 9) begin errors++; $display("[TB] FAIL def_first_at got=%0d exp=9", first); end
        checks++; if (pulses != 12) begin errors++; $display("[TB] FAIL def_pulses got=%0d exp=12", pulses); end
    endtask

    task automatic test_gapped_reload();
        cycle(1'b0, 16'h0, 1'b1, 7'd3);
        checks++; if (bus.cur_len !== 7'd3 || bus.primed !== 1'b0) begin errors++; $display("[TB] FAIL gap_load len=%0d primed=%b exp=3/0", bus.cur_len, bus.primed); end
        for (int i = 100; i <= 110; i++) begin
            cycle(1'b1, 16'(i), 1'b0, 7'd0);
            checks++; if (bus.d_out_val !== exp_val || bus.d_out !== exp_out) begin errors++; $display("[TB] FAIL gap_out in=%0d got=%b/%h exp=%b/%h", i, bus.d_out_val, bus.d_out, exp_val, exp_out); end
            if (i == 103) begin
                checks++; if (bus.d_out !== 16'd100 || bus.d_out_val !== 1'b1) begin errors++; $display("[TB] FAIL gap_103 got=%b/%0d exp=1/100", bus.d_out_val, bus.d_out); end
            end
            for (int g = 0; g < 2; g++) begin
                cycle(1'b0, 16'($urandom), 1'b0, 7'd0);
                checks++; if (bus.d_out_val !== 1'b0) begin errors++; $display("[TB] FAIL gap_idle got=%b exp=0", bus.d_out_val); end
            end
        end
    endtask

    task automatic test_max_len();
        int pulses = 0;
        cycle(1'b0, 16'h0, 1'b1, 7'd64);
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 16'($urandom), 1'b0, 7'd0);
            if (bus.d_out_val === 1'b1) pulses++;
            checks++; if (bus.d_out_val !== exp_val || bus.d_out !== exp_out) begin errors++; $display("[TB] FAIL max_out k=%0d got=%b/%h exp=%b/%h", i, bus.d_out_val, bus.d_out, exp_val, exp_out); end
        end
        checks++; if (pulses != 136) begin errors++; $display("[TB] FAIL max_pulses got=%0d exp=136", pulses); end
    endtask

    task automatic test_cfg_err();
        logic [6:0] bad [2];
        bad[0] = 7'd0;
        bad[1] = 7'd65;
        for (int b = 0; b < 2; b++) begin
            cycle(1'b1, 16'($urandom), 1'b1, bad[b]);
            checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL err_pulse len=%0d got=%b exp=1", bad[b], bus.cfg_err); end
            checks++; if (bus.cur_len !== 7'd64 || bus.primed !== 1'b1) begin errors++; $display("[TB] FAIL err_keep len=%0d got=%0d/%b exp=64/1", bad[b], bus.cur_len, bus.primed); end
            checks++; if (bus.d_out_val !== exp_val || bus.d_out !== exp_out) begin errors++; $display("[TB] FAIL err_stream got=%b/%h exp=%b/%h", bus.d_out_val, bus.d_out, exp_val, exp_out); end
            cycle(1'b1, 16'($urandom), 1'b0, 7'd0);
            checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear got=%b exp=0", bus.cfg_err); end
        end
    endtask

    task automatic test_len1_coincident();
        cycle(1'b1, 16'd7, 1'b1, 7'd1);
        checks++; if (bus.d_out_val !== 1'b0 || bus.primed !== 1'b1 || bus.cur_len !== 7'd1) begin errors++; $display("[TB] FAIL len1_load got=%b/%b/%0d exp=0/1/1", bus.d_out_val, bus.primed, bus.cur_len); end
        cycle(1'b1, 16'd8, 1'b0, 7'd0);
        checks++; if (bus.d_out_val !== 1'b1 || bus.d_out !== 16'd7) begin errors++; $display("[TB] FAIL len1_out got=%b/%0d exp=1/7", bus.d_out_val, bus.d_out); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 16'd55, 1'b0, 7'd0);
        checks++; if (bus.d_out_val !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pending got=%b exp=1", bus.d_out_val); end
        rst = 1'b0;
        cycle(1'b1, 16'd56, 1'b0, 7'd0);
        rst = 1'b1;
        checks++; if (bus.d_out_val !== 1'b0 || bus.cur_len !== 7'd8 || bus.primed !== 1'b0) begin errors++; $display("[TB] FAIL rmid_reset got=%b/%0d/%b exp=0/8/0", bus.d_out_val, bus.cur_len, bus.primed); end
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b1, 16'(300 + i), 1'b0, 7'd0);
            checks++; if (bus.d_out_val !== exp_val || bus.d_out !== exp_out) begin errors++; $display("[TB] FAIL rmid_out in=%0d got=%b/%h exp=%b/%h", i, bus.d_out_val, bus.d_out, exp_val, exp_out); end
        end
        checks++; if (bus.d_out !== 16'd301) begin errors++; $display("[TB] FAIL rmid_first got=%0d exp=301", bus.d_out); end
    endtask

    task automatic test_random();
        logic       v;
        logic       ld;
        logic [6:0] len;
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 24) == 0);
            len = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(65, 127)) : 7'($urandom_range(0, 20));
            cycle(v, 16'($urandom), ld, len);
            checks++; if (bus.d_out_val !== exp_val || bus.d_out !== exp_out) begin errors++; $display("[TB] FAIL rnd_out i=%0d got=%b/%h exp=%b/%h", i, bus.d_out_val, bus.d_out, exp_val, exp_out); end
            checks++; if (bus.cfg_err !== exp_err) begin errors++; $display("[TB] FAIL rnd_err i=%0d got=%b exp=%b", i, bus.cfg_err, exp_err); end
            checks++; if (bus.primed !== exp_primed || bus.cur_len !== 7'(len_m)) begin errors++; $display("[TB] FAIL rnd_state i=%0d got=%b/%0d exp=%b/%0d", i, bus.primed, bus.cur_len, exp_primed, len_m); end
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        len_m        = 8;
        rst          = 1'b0;
        bus.cfg_len  = '0;
        bus.cfg_load = 1'b0;
        bus.d_in     = '0;
        bus.d_in_val = 1'b0;
        test_reset();
        test_default_stream();
        test_gapped_reload();
        test_max_len();
        test_cfg_err();
        test_len1_coincident();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
